// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock parametrised FIFO with a fill-level count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags and a selectable first-word-fall-through read mode.
// Pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2*DEPTH. The low
// ADDR_WIDTH bits address memory. The occupancy is tracked by an explicit
// count register, and all level flags are decoded from that register.
module param_sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ZERO_C   = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic [DATA_WIDTH-1:0] head_s;

  // Level flags come straight from the count register so they move with count.
  assign full_s       = (count_r == DEPTH_C);
  assign empty_s      = (count_r == ZERO_C);
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AFULL_C);
  assign almost_empty = (count_r <= AEMPTY_C);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // A write is refused on a full FIFO even if a read is accepted in the same cycle.
  assign wr_ok_s = wr_en && !full_s;
  assign rd_ok_s = rd_en && !empty_s;
  assign head_s  = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];

  // Storage array: written on accepted writes only and never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
      count_r  <= ZERO_C;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags: a new error wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is presented directly. An empty FIFO shows zero.
      assign dout = empty_s ? {DATA_WIDTH{1'b0}} : head_s;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_r;

      // Registered read port: the popped word lands one edge after rd_en.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_ok_s) begin
          dout_r <= head_s;
        end else begin
          dout_r <= dout_r;
        end
      end

      assign dout = dout_r;
    end
  endgenerate

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock, parametrised FIFO. It is the next generation of the team's FIFO buffer, adding a fill-level count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It is used as the general-purpose buffer between producer/consumer blocks sharing one clock domain.

Parameters:
DATA_WIDTH, 8, data word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AFULL_THRESH, 14, almost_full asserted when count >= this; legal 1..DEPTH
AEMPTY_THRESH, 2, almost_empty asserted when count <= this; legal 0..DEPTH-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read/pop request
clr_err  in  1  clears overflow/underflow
dout  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  current number of stored words, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous, immediate): wr/rd pointers=0, count=0, dout=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared. Reset asserted mid-transfer discards all stored words.
- Pointers: ADDR_WIDTH+1-bit binary; the low ADDR_WIDTH bits address memory. They wrap naturally modulo 2*DEPTH.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= din; wr_ptr++. A write while full is dropped, and memory and pointers are unchanged.
- Read accepted iff rd_en && !empty: rd_ptr++. A read while empty is ignored.
- Both flags use the registered count as it stands before the edge. A write is never accepted on a full FIFO, even if a read is accepted in the same cycle.
- count is a register:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- full, empty, almost_full and almost_empty are decoded combinationally from the count register, so they change in the same cycle as count.
- Standard mode (FWFT=0):
  - On an accepted read, dout <= mem[rd_ptr] at that edge (1-cycle latency).
  - Otherwise dout holds its last value.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] whenever !empty, and is forced to 0 when empty.
  - A word written at edge N appears on dout after edge N.
  - An accepted rd_en pops the word, and the next word appears after that edge.
- Simultaneous write and read when count==1 (FWFT): the old head is popped and the new word becomes the head. count stays 1.
- overflow is set at an edge where wr_en && full. underflow is set at an edge where rd_en && empty.
- clr_err clears both error flags at the edge. If a set condition and clr_err occur in the same cycle, set wins.
- Error flags are not cleared by normal traffic.

Test Plan:
- Reset then fill: write 0x01..0x10 on 16 consecutive cycles (FWFT=0) -> count 1..16; almost_full rises when count=14; full=1 after the 16th edge; empty=0 after the 1st edge.
- Overflow: on a full FIFO, wr_en=1 with din=0xAA -> count stays 16; overflow=1 next cycle; a subsequent drain returns 0x01..0x10 with no 0xAA.
- Drain and underflow (FWFT=0): 16 reads -> dout=0x01..0x10, each one cycle after its rd_en edge; almost_empty rises at count=2; empty at 0. An extra rd_en -> underflow=1, and dout holds 0x10.
- Simultaneous read and write at count=8 for 20 cycles -> count constant at 8; data order preserved across the pointer wrap.
- FWFT=1: write 0x5A to an empty FIFO -> dout=0x5A and empty=0 after that edge with no rd_en. Pop with a simultaneous write of 0x6B -> dout=0x6B and count=1.
- Asynchronous reset: drop rst_n mid-cycle with count=9 and overflow=1 -> count=0, empty=1, overflow=0 and dout=0 immediately, without waiting for a clk edge. clr_err asserted in the same cycle as an overflow event -> overflow remains 1.
